md_scheduler: RTL and testbench
===============================

// Module: md_scheduler
// PURPOSE
//  Multiply/divide sequencer for the E stage. Accepts one MD op from the decoder,
//  holds the unit busy for a fixed multi-cycle latency, then commits HI/LO.
//  Drives the D-stage stall for MD-class instructions while an op is in flight.
//  Also serves MTHI/MTLO writes and MFHI/MFLO reads.
// PARAMETERS
//  WIDTH       32  operand / HI / LO width
//  MUL_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES  10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous, active-low reset
//  Start    in   1      E-stage MD op valid this cycle
//  MDOp     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  A        in   WIDTH  rs operand
//  B        in   WIDTH  rt operand
//  MFSel    in   1      read select: 0 LO, 1 HI
//  MDUseD   in   1      D-stage instr is MD-class (mult/div/mf*/mt*)
//  Busy     out  1      op in flight
//  Stall    out  1      stall request to D stage
//  HI       out  WIDTH  architectural HI
//  LO       out  WIDTH  architectural LO
//  MDOut    out  WIDTH  MFSel ? HI : LO (combinational)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, cnt=0, HI=LO=0, shadows=0, Busy=0.
//    Reset mid-op abandons the op; HI/LO stay 0.
//  - FSM states: IDLE, MUL, DIV. Busy = (state!=IDLE).
//  - Start is sampled only in IDLE; Start while Busy is ignored
//    (hazard logic guarantees it never occurs).
//  - IDLE, Start, MDOp=MULT/MULTU:
//    - product latched into shadow {sHI,sLO} (signed/unsigned 2*WIDTH).
//    - cnt<=MUL_CYCLES, state<=MUL.
//  - IDLE, Start, MDOp=DIV/DIVU:
//    - sLO=quotient, sHI=remainder.
//    - cnt<=DIV_CYCLES, state<=DIV.
//  - MUL/DIV: cnt decrements each edge. At the edge where cnt==1:
//    - HI<=sHI, LO<=sLO, state<=IDLE.
//    - So Busy is high for exactly N cycles after the start edge.
//    - New HI/LO are visible after start edge + N.
//  - Signed divide truncates toward zero; remainder takes the dividend's sign.
//  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
//  - Divide by zero: full DIV_CYCLES busy, HI/LO unchanged at commit.
//  - IDLE, Start, MTHI/MTLO: HI<=A or LO<=A at that edge. No busy, no stall.
//  - Reserved MDOp values (110, 111): ignored, state stays IDLE.
//  - Stall = MDUseD & (Busy | (Start & MDOp is MULT/MULTU/DIV/DIVU)).
//    - Stall is held through the final busy cycle.
//    - It drops the cycle after commit.
//  - MDOut reads the committed HI/LO only, never the shadows.
// TESTING
//  1 MULT A=-3 B=7, start edge 0:
//    -> Busy=1 cycles 1..5, then HI=0xFFFFFFFF, LO=0xFFFFFFEB after edge 5.
//  2 MULTU A=0xFFFFFFFF B=2:
//    -> after MUL_CYCLES, HI=0x1, LO=0xFFFFFFFE.
//  3 DIV A=-7 B=2:
//    -> after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    -> DIV with B=0 leaves HI/LO unchanged.
//  4 MULT then MDUseD=1 held:
//    -> Stall=1 from the start cycle through the last busy cycle, 0 after.
//    -> Stall=0 whenever MDUseD=0.
//  5 MTHI A=0x1234, then MFSel=1:
//    -> HI=0x1234 the next cycle, MDOut=0x1234, Busy stays 0.
//  6 DIV started, rst_n pulsed low at busy cycle 4:
//    -> Busy, HI, LO are 0 immediately.
//    -> No later commit occurs.

Source files
------------

// File: rtl/md_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : md_scheduler
//  Description : Multiply/divide sequencer for the E stage. Computes the
//                MULT/MULTU/DIV/DIVU result into shadow registers at the start
//                edge, holds the unit busy for a fixed latency, then commits
//                HI/LO. Serves MTHI/MTLO writes, MFHI/MFLO reads and the
//                D-stage stall request for MD-class instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module md_scheduler #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Start,
   input  logic [2:0]       MDOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             MFSel,
   input  logic             MDUseD,
   output logic             Busy,
   output logic             Stall,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] MDOut
);

   // FSM encoding
   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_MUL  = 2'd1;
   localparam logic [1:0] c_DIV  = 2'd2;

   // Counter sized for the longer of the two latencies
   localparam int c_MAXN = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int c_CW   = $clog2(c_MAXN + 1);
   localparam logic [c_CW-1:0] c_MULN = c_CW'(MUL_CYCLES);
   localparam logic [c_CW-1:0] c_DIVN = c_CW'(DIV_CYCLES);
   localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

   logic [1:0]       r_state;
   logic [1:0]       w_nstate;
   logic [c_CW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_shi;
   logic [WIDTH-1:0] r_slo;

   // Op class decode; MDOp[0] selects the unsigned variant
   logic w_is_mul;
   logic w_is_div;
   logic w_unsigned;
   logic w_last;

   assign w_is_mul   = (MDOp[2:1] == 2'b00);
   assign w_is_div   = (MDOp[2:1] == 2'b01);
   assign w_unsigned = MDOp[0];
   assign w_last     = (r_cnt == c_ONE);

   // Shared multiplier: operands extended to 2*WIDTH by sign or zero
   logic [2*WIDTH-1:0] w_mul_a;
   logic [2*WIDTH-1:0] w_mul_b;
   logic [2*WIDTH-1:0] w_prod;

   assign w_mul_a = {{WIDTH{A[WIDTH-1] & ~w_unsigned}}, A};
   assign w_mul_b = {{WIDTH{B[WIDTH-1] & ~w_unsigned}}, B};
   assign w_prod  = w_mul_a * w_mul_b;

   // Shared unsigned divider; signed ops divide magnitudes and fix signs after,
   // giving truncation toward zero and a remainder with the dividend's sign
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_dvd;
   logic [WIDTH-1:0] w_dvs;
   logic [WIDTH-1:0] w_dvs_safe;
   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_r;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic             w_div_zero;

   assign w_a_neg    = A[WIDTH-1] & ~w_unsigned;
   assign w_b_neg    = B[WIDTH-1] & ~w_unsigned;
   assign w_dvd      = w_a_neg ? (~A + WIDTH'(1)) : A;
   assign w_dvs      = w_b_neg ? (~B + WIDTH'(1)) : B;
   assign w_div_zero = (B == '0);
   // Divisor forced nonzero so the divider never sees /0; result is discarded then
   assign w_dvs_safe = w_div_zero ? WIDTH'(1) : w_dvs;
   assign w_q        = w_dvd / w_dvs_safe;
   assign w_r        = w_dvd % w_dvs_safe;
   assign w_quot     = (w_a_neg ^ w_b_neg) ? (~w_q + WIDTH'(1)) : w_q;
   assign w_rem      = w_a_neg ? (~w_r + WIDTH'(1)) : w_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_nstate;
      end
   end

   // Next-state logic: launch from IDLE, return on the final busy cycle
   always_comb begin
      w_nstate = r_state;
      case (r_state)
         c_IDLE: begin
            if (Start && w_is_mul) begin
               w_nstate = c_MUL;
            end else if (Start && w_is_div) begin
               w_nstate = c_DIV;
            end
         end
         c_MUL, c_DIV: begin
            if (w_last) begin
               w_nstate = c_IDLE;
            end
         end
         default: w_nstate = c_IDLE;
      endcase
   end

   // Output logic: busy flag, D-stage stall and the MFHI/MFLO read mux
   always_comb begin
      Busy  = (r_state != c_IDLE);
      Stall = MDUseD & (Busy | (Start & (w_is_mul | w_is_div)));
      MDOut = MFSel ? r_hi : r_lo;
   end

   // Datapath: latch result into shadows at start, count down, commit at the end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_shi <= '0;
         r_slo <= '0;
      end else if (r_state == c_IDLE) begin
         if (Start) begin
            case (MDOp)
               3'b000, 3'b001: begin
                  r_shi <= w_prod[2*WIDTH-1:WIDTH];
                  r_slo <= w_prod[WIDTH-1:0];
                  r_cnt <= c_MULN;
               end
               3'b010, 3'b011: begin
                  // Divide by zero recommits the current HI/LO unchanged
                  r_shi <= w_div_zero ? r_hi : w_rem;
                  r_slo <= w_div_zero ? r_lo : w_quot;
                  r_cnt <= c_DIVN;
               end
               3'b100:  r_hi <= A;
               3'b101:  r_lo <= A;
               default: ;
            endcase
         end
      end else begin
         r_cnt <= r_cnt - c_ONE;
         if (w_last) begin
            r_hi <= r_shi;
            r_lo <= r_slo;
         end
      end
   end

   assign HI = r_hi;
   assign LO = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_scheduler
//  Description : Self-checking bench for md_scheduler. Directed cases plus
//                randomized ops compared against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_scheduler;

   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic         Start  = 1'b0;
   logic [2:0]   MDOp   = 3'b0;
   logic [W-1:0] A      = '0;
   logic [W-1:0] B      = '0;
   logic         MFSel  = 1'b0;
   logic         MDUseD = 1'b0;
   logic         Busy;
   logic         Stall;
   logic [W-1:0] HI;
   logic [W-1:0] LO;
   logic [W-1:0] MDOut;

   int passed = 0;
   int total  = 0;

   // Expected architectural HI/LO
   logic [W-1:0] mhi = '0;
   logic [W-1:0] mlo = '0;

   md_scheduler #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .Start  (Start),
      .MDOp   (MDOp),
      .A      (A),
      .B      (B),
      .MFSel  (MFSel),
      .MDUseD (MDUseD),
      .Busy   (Busy),
      .Stall  (Stall),
      .HI     (HI),
      .LO     (LO),
      .MDOut  (MDOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int lat(input logic [2:0] op);
      if (op == 3'd0 || op == 3'd1) return MC;
      if (op == 3'd2 || op == 3'd3) return DC;
      return 0;
   endfunction

   // Reference arithmetic: returns {HI,LO} after the op given the old values
   function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] ohi,
                                            input logic [W-1:0] olo);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: begin p = 64'(sa * sb); return p; end
         3'd1: begin p = {32'b0, a} * {32'b0, b}; return p; end
         3'd2: begin
            if (b == '0) return {ohi, olo};
            q = sa / sb;
            r = sa % sb;
            return {r[W-1:0], q[W-1:0]};
         end
         3'd3: begin
            if (b == '0) return {ohi, olo};
            return {a % b, a / b};
         end
         3'd4: return {a, olo};
         3'd5: return {ohi, a};
         default: return {ohi, olo};
      endcase
   endfunction

   // Issue one op and follow it cycle by cycle until HI/LO are final
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit rand_use);
      int n;
      logic use_d;
      logic [2*W-1:0] res;
      n     = lat(op);
      use_d = rand_use ? 1'($urandom_range(0, 1)) : 1'b1;
      res   = model(op, a, b, mhi, mlo);
      Start = 1'b1; MDOp = op; A = a; B = b; MDUseD = use_d;
      #1;
      chk("busy_at_start", W'(Busy), W'(1'b0));
      chk("stall_at_start", W'(Stall), W'(use_d && (n > 0)));
      tick();
      Start = 1'b0; MDOp = 3'($urandom); A = $urandom; B = $urandom;
      for (int i = 0; i < n; i++) begin
         use_d  = rand_use ? 1'($urandom_range(0, 1)) : 1'b1;
         MDUseD = use_d;
         #1;
         chk("busy_inflight", W'(Busy), W'(1'b1));
         chk("stall_inflight", W'(Stall), W'(use_d));
         chk("hi_held", HI, mhi);
         chk("lo_held", LO, mlo);
         tick();
      end
      mhi    = res[2*W-1:W];
      mlo    = res[W-1:0];
      MDUseD = rand_use ? 1'($urandom_range(0, 1)) : 1'b1;
      MFSel  = 1'($urandom_range(0, 1));
      #1;
      chk("busy_after", W'(Busy), W'(1'b0));
      chk("stall_after", W'(Stall), W'(1'b0));
      chk("hi_commit", HI, mhi);
      chk("lo_commit", LO, mlo);
      chk("mdout", MDOut, MFSel ? mhi : mlo);
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] a, b;

      // Reset state
      #1;
      chk("rst_busy", W'(Busy), W'(1'b0));
      chk("rst_stall", W'(Stall), W'(1'b0));
      chk("rst_hi", HI, '0);
      chk("rst_lo", LO, '0);
      chk("rst_mdout", MDOut, '0);
      #1 rst_n = 1'b1;
      tick();

      // Directed cases
      run_op(3'd0, -32'sd3, 32'sd7, 1'b0);
      chk("mult_hi_const", HI, 32'hFFFF_FFFF);
      chk("mult_lo_const", LO, 32'hFFFF_FFEB);
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      chk("multu_hi_const", HI, 32'h0000_0001);
      chk("multu_lo_const", LO, 32'hFFFF_FFFE);
      run_op(3'd2, -32'sd7, 32'sd2, 1'b0);
      chk("div_lo_const", LO, 32'hFFFF_FFFD);
      chk("div_hi_const", HI, 32'hFFFF_FFFF);
      run_op(3'd2, 32'd99, 32'd0, 1'b1);
      chk("divz_lo_kept", LO, 32'hFFFF_FFFD);
      run_op(3'd3, 32'd1234, 32'd0, 1'b1);
      run_op(3'd4, 32'h0000_1234, 32'd0, 1'b0);
      MFSel = 1'b1;
      #1;
      chk("mthi_mdout", MDOut, 32'h0000_1234);
      run_op(3'd5, 32'hCAFE_0001, 32'd0, 1'b1);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      chk("ovf_lo_const", LO, 32'h8000_0000);
      chk("ovf_hi_const", HI, 32'h0000_0000);
      run_op(3'd6, 32'h5555_5555, 32'd1, 1'b1);
      run_op(3'd7, 32'hAAAA_AAAA, 32'd1, 1'b1);

      // Randomized ops
      for (int k = 0; k < 60; k++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         case ($urandom_range(0, 4))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 9));
            2:       b = W'(-int'($urandom_range(1, 9)));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         run_op(op, a, b, 1'b1);
      end

      // Make HI/LO nonzero, then abandon a DIV with reset at busy cycle 4
      run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd3; MDUseD = 1'b0;
      tick();
      Start = 1'b0;
      for (int i = 1; i < 4; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      mhi = '0;
      mlo = '0;
      chk("midrst_busy", W'(Busy), W'(1'b0));
      chk("midrst_hi", HI, '0);
      chk("midrst_lo", LO, '0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < DC + 2; i++) begin
         tick();
         chk("postrst_busy", W'(Busy), W'(1'b0));
         chk("postrst_hi", HI, '0);
         chk("postrst_lo", LO, '0);
      end
      run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Hard stop in case the sequence never completes
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
